pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Program-counter stage of the single-cycle CPU. Holds the architectural PC and drives it to the instruction-memory fetch port and to the PC+4 incrementer.
- Consumes the incrementer result as the sequential next PC.
- Selects the next PC among sequential, branch, jump and trap redirects.
- Owns the fetch valid/ready handshake, a pending-redirect buffer and a halt/resume controller.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0080, target address applied on TRAP.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PC_OUT  out  32  current PC; this is the fetch address and feeds the incrementer input.
- PC_PLUS4  in  32  incrementer output (PC_OUT+4, combinational).
- FETCH_VALID  out  1  fetch request valid.
- FETCH_READY  in  1  instruction memory accepts the request.
- BR_TAKEN  in  1  branch redirect request.
- BR_TARGET  in  32  branch target.
- JMP  in  1  jump redirect request.
- JMP_TARGET  in  32  jump target.
- TRAP  in  1  trap redirect request; target is TRAP_VEC.
- HALT_REQ  in  1  request to stop fetching.
- RESUME  in  1  leave the halted state.
- HALTED  out  1  high while in the HALTED state.
- REDIRECT_PENDING  out  1  a buffered redirect is waiting for the handshake.

Behaviour:
- Reset (async, RST_N=0):
  - PC_OUT=RESET_PC, FETCH_VALID=0, HALTED=0, REDIRECT_PENDING=0, pending target=0.
  - State=BOOT.
  - Reset mid-request abandons the request without waiting for the handshake.
- States:
  - BOOT: one cycle with FETCH_VALID=0, then unconditionally to RUN.
  - RUN: FETCH_VALID=1.
  - DRAIN: FETCH_VALID=1; waiting for the outstanding fetch to be accepted.
  - HALTED: FETCH_VALID=0, HALTED=1.
- Handshake:
  - Fires when FETCH_VALID&FETCH_READY.
  - While FETCH_VALID=1 and no handshake, PC_OUT is held stable.
  - FETCH_VALID never drops before the handshake.
- Redirect select, priority TRAP > JMP > BR_TAKEN:
  - TRAP selects TRAP_VEC, JMP selects JMP_TARGET, BR_TAKEN selects BR_TARGET.
  - The "live redirect" is the highest-priority asserted request.
- Next PC on handshake in RUN/DRAIN:
  - live redirect target if one is present;
  - else the pending target if REDIRECT_PENDING=1;
  - else PC_PLUS4.
  - The pending entry is cleared on the handshake.
- Live redirect with no handshake (RUN/DRAIN):
  - Target is written to the pending register and REDIRECT_PENDING is set.
  - A later redirect overwrites the pending entry (youngest wins).
  - PC_OUT is unchanged.
- Redirect in HALTED or BOOT: PC_OUT loads the target on the next edge; no pending entry is created.
- Halt and resume:
  - HALT_REQ in RUN with a handshake in the same cycle: PC updates, then HALTED.
  - HALT_REQ in RUN without a handshake: go to DRAIN.
  - DRAIN with a handshake: PC updates, then HALTED.
  - RESUME in HALTED: go to RUN.
  - HALT_REQ together with RESUME in HALTED: stay HALTED.
  - REDIRECT_PENDING=1 on entering HALTED: the pending target is loaded into PC on entry and the entry is cleared.
- Arithmetic: no internal adder. Wrap-around is whatever PC_PLUS4 delivers (0xFFFF_FFFC -> 0x0000_0000) and is accepted silently.
- Latency:
  - A redirect coincident with a handshake is visible on PC_OUT next cycle.
  - A buffered redirect is visible the cycle after the handshake.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- When defined:
  - Adds output MISALIGN (1 bit, reset 0), set when a selected redirect target has bits[1:0]!=0.
  - MISALIGN is sticky until reset.
  - The loaded PC is forced to {target[31:2],2'b00}.
- When undefined: no MISALIGN port, and the target is loaded unmodified.

Decomposition:
- Package pc_pkg holds:
  - the state enum (BOOT, RUN, DRAIN, HALTED);
  - the redirect-source encoding (NONE, BR, JMP, TRAP);
  - width constant PC_W=32.
- One natural sub-module, pc_redirect_sel: combinational priority encoder plus target mux, outputting the live-redirect flag and the selected target.

Test Plan:
- Reset release, FETCH_READY tied 1 -> PC_OUT=0 during BOOT; FETCH_VALID rises at cycle 1; PC_OUT then steps 0,4,8,C on consecutive cycles.
- FETCH_READY=0 for 3 cycles at PC=0x10 with BR_TAKEN, BR_TARGET=0x200 in cycle 1 -> PC_OUT holds 0x10 and REDIRECT_PENDING=1; on the handshake PC becomes 0x200 and pending clears.
- Same cycle TRAP=1, JMP=1 (JMP_TARGET=0x40), BR_TAKEN=1, handshake -> PC_OUT=0x80.
- HALT_REQ with FETCH_READY=0 for 2 cycles -> DRAIN with FETCH_VALID held, then HALTED=1 and FETCH_VALID=0 after the handshake. JMP to 0x300 while halted -> PC_OUT=0x300. RESUME -> fetch restarts at 0x300.
- PC=0xFFFF_FFFC, handshake, PC_PLUS4=0 -> PC_OUT=0x0.
- With PC_ALIGN_CHECK_EN: BR_TARGET=0x106 -> PC_OUT=0x104 and MISALIGN=1, still 1 after later aligned jumps. Deassert RST_N mid-DRAIN -> immediate PC_OUT=RESET_PC, FETCH_VALID=0, MISALIGN=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the PC fetch stage: FSM states, redirect-source encoding, PC width.
// PC_ALIGN_CHECK_EN (optional) enables target alignment and the MISALIGN flag.
package pc_pkg;

  localparam int PC_W = 32;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_BR,
    SRC_JMP,
    SRC_TRAP
  } redir_src_e;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority encoder (TRAP > JMP > BR) and target mux for PC redirects.
module pc_redirect_sel
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            jmp,
  input  logic [PC_W-1:0] jmp_target,
  input  logic            trap,
  output logic            live,
  output logic [PC_W-1:0] target
);

  redir_src_e src;

  always_comb begin
    src = SRC_NONE;
    if (trap)          src = SRC_TRAP;
    else if (jmp)      src = SRC_JMP;
    else if (br_taken) src = SRC_BR;
  end

  always_comb begin
    target = '0;
    case (src)
      SRC_TRAP: target = TRAP_VEC;
      SRC_JMP:  target = jmp_target;
      SRC_BR:   target = br_target;
      default:  target = '0;
    endcase
  end

  assign live = (src != SRC_NONE);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC stage: holds the PC, owns the fetch handshake, pending-redirect buffer and halt control.
// Optional PC_ALIGN_CHECK_EN forces word-aligned targets and adds a sticky MISALIGN output.
module pc_fetch_unit
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_W-1:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic            CLK,
  input  logic            RST_N,
  output logic [PC_W-1:0] PC_OUT,
  input  logic [PC_W-1:0] PC_PLUS4,
  output logic            FETCH_VALID,
  input  logic            FETCH_READY,
  input  logic            BR_TAKEN,
  input  logic [PC_W-1:0] BR_TARGET,
  input  logic            JMP,
  input  logic [PC_W-1:0] JMP_TARGET,
  input  logic            TRAP,
  input  logic            HALT_REQ,
  input  logic            RESUME,
  output logic            HALTED,
`ifdef PC_ALIGN_CHECK_EN
  output logic            MISALIGN,
`endif
  output logic            REDIRECT_PENDING
);

  pc_state_e       state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;
  logic            pend_q, pend_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;

  logic            live;
  logic [PC_W-1:0] sel_tgt;
  logic [PC_W-1:0] redir_tgt;
  logic            hs;

  pc_redirect_sel #(.TRAP_VEC(TRAP_VEC)) u_sel (
    .br_taken  (BR_TAKEN),
    .br_target (BR_TARGET),
    .jmp       (JMP),
    .jmp_target(JMP_TARGET),
    .trap      (TRAP),
    .live      (live),
    .target    (sel_tgt)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;
  assign redir_tgt  = align_pc(sel_tgt);
  assign misalign_d = misalign_q | (live & (|sel_tgt[1:0]));
  assign MISALIGN   = misalign_q;
`else
  assign redir_tgt  = sel_tgt;
`endif

  assign hs = valid_q & FETCH_READY;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    case (state_q)
      ST_BOOT: begin
        if (live) pc_d = redir_tgt;
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      ST_RUN, ST_DRAIN: begin
        if (hs) begin
          // A live redirect outranks an older buffered one.
          if (live)        pc_d = redir_tgt;
          else if (pend_q) pc_d = pend_tgt_q;
          else             pc_d = PC_PLUS4;
          pend_d     = 1'b0;
          pend_tgt_d = '0;
          if (HALT_REQ || state_q == ST_DRAIN) begin
            state_d  = ST_HALTED;
            valid_d  = 1'b0;
            halted_d = 1'b1;
          end
        end else begin
          if (live) begin
            pend_d     = 1'b1;
            pend_tgt_d = redir_tgt;
          end
          if (state_q == ST_RUN && HALT_REQ) state_d = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (live) pc_d = redir_tgt;
        if (RESUME && !HALT_REQ) begin
          state_d  = ST_RUN;
          valid_d  = 1'b1;
          halted_d = 1'b0;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
`endif

  assign PC_OUT           = pc_q;
  assign FETCH_VALID      = valid_q;
  assign HALTED           = halted_q;
  assign REDIRECT_PENDING = pend_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected state queued per step, compared after each edge.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] PC_OUT, PC_PLUS4;
  logic        FETCH_VALID, FETCH_READY;
  logic        BR_TAKEN, JMP, TRAP, HALT_REQ, RESUME;
  logic [31:0] BR_TARGET, JMP_TARGET;
  logic        HALTED, REDIRECT_PENDING;
`ifdef PC_ALIGN_CHECK_EN
  logic        MISALIGN;
`endif

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v, h, p;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   npass = 0;

  assign PC_PLUS4 = PC_OUT + 32'd4;

  pc_fetch_unit dut (
    .CLK(CLK), .RST_N(RST_N), .PC_OUT(PC_OUT), .PC_PLUS4(PC_PLUS4),
    .FETCH_VALID(FETCH_VALID), .FETCH_READY(FETCH_READY),
    .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET), .JMP(JMP), .JMP_TARGET(JMP_TARGET),
    .TRAP(TRAP), .HALT_REQ(HALT_REQ), .RESUME(RESUME), .HALTED(HALTED),
`ifdef PC_ALIGN_CHECK_EN
    .MISALIGN(MISALIGN),
`endif
    .REDIRECT_PENDING(REDIRECT_PENDING)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    assert (act === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic v, h, p);
    exp_t e;
    e.tag = tag; e.pc = pc; e.v = v; e.h = h; e.p = p;
    q.push_back(e);
  endtask

  task automatic drain_check();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".pc"},     PC_OUT,                   e.pc);
      chk({e.tag, ".valid"},  {31'd0, FETCH_VALID},      {31'd0, e.v});
      chk({e.tag, ".halted"}, {31'd0, HALTED},           {31'd0, e.h});
      chk({e.tag, ".pend"},   {31'd0, REDIRECT_PENDING}, {31'd0, e.p});
    end
  endtask

  task automatic step(input string tag, input logic [31:0] pc, input logic v, h, p);
    push(tag, pc, v, h, p);
    @(posedge CLK);
    #1;
    drain_check();
  endtask

  initial begin
    RST_N = 1'b0; FETCH_READY = 1'b1;
    BR_TAKEN = 1'b0; JMP = 1'b0; TRAP = 1'b0; HALT_REQ = 1'b0; RESUME = 1'b0;
    BR_TARGET = '0; JMP_TARGET = '0;
    #2;
    push("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    drain_check();
`ifdef PC_ALIGN_CHECK_EN
    chk("reset.misalign", {31'd0, MISALIGN}, 32'd0);
`endif
    @(posedge CLK); #1;
    RST_N = 1'b1;
    push("boot", 32'h0, 1'b0, 1'b0, 1'b0);
    drain_check();

    // Sequential fetch
    step("run0", 32'h0,  1'b1, 1'b0, 1'b0);
    step("seq4", 32'h4,  1'b1, 1'b0, 1'b0);
    step("seq8", 32'h8,  1'b1, 1'b0, 1'b0);
    step("seqC", 32'hC,  1'b1, 1'b0, 1'b0);
    step("seq10", 32'h10, 1'b1, 1'b0, 1'b0);

    // Branch buffered during stall
    FETCH_READY = 1'b0; BR_TAKEN = 1'b1; BR_TARGET = 32'h200;
    step("stall1", 32'h10, 1'b1, 1'b0, 1'b1);
    BR_TAKEN = 1'b0;
    step("stall2", 32'h10, 1'b1, 1'b0, 1'b1);
    step("stall3", 32'h10, 1'b1, 1'b0, 1'b1);
    FETCH_READY = 1'b1;
    step("pend_hs", 32'h200, 1'b1, 1'b0, 1'b0);

    // Priority
    TRAP = 1'b1; JMP = 1'b1; JMP_TARGET = 32'h40; BR_TAKEN = 1'b1; BR_TARGET = 32'h500;
    step("prio", 32'h80, 1'b1, 1'b0, 1'b0);
    TRAP = 1'b0; JMP = 1'b0;

    // Youngest pending wins
    FETCH_READY = 1'b0; BR_TARGET = 32'h300;
    step("young1", 32'h80, 1'b1, 1'b0, 1'b1);
    BR_TAKEN = 1'b0; JMP = 1'b1; JMP_TARGET = 32'h400;
    step("young2", 32'h80, 1'b1, 1'b0, 1'b1);
    JMP = 1'b0; FETCH_READY = 1'b1;
    step("young_hs", 32'h400, 1'b1, 1'b0, 1'b0);

    // Live redirect beats pending on handshake
    FETCH_READY = 1'b0; BR_TAKEN = 1'b1; BR_TARGET = 32'h600;
    step("live1", 32'h400, 1'b1, 1'b0, 1'b1);
    BR_TAKEN = 1'b0; JMP = 1'b1; JMP_TARGET = 32'h700; FETCH_READY = 1'b1;
    step("live_hs", 32'h700, 1'b1, 1'b0, 1'b0);
    JMP = 1'b0;
    step("seq704", 32'h704, 1'b1, 1'b0, 1'b0);

    // Halt through DRAIN
    HALT_REQ = 1'b1; FETCH_READY = 1'b0;
    step("drain1", 32'h704, 1'b1, 1'b0, 1'b0);
    HALT_REQ = 1'b0;
    step("drain2", 32'h704, 1'b1, 1'b0, 1'b0);
    FETCH_READY = 1'b1;
    step("halt_in", 32'h708, 1'b0, 1'b1, 1'b0);
    step("halt_hold", 32'h708, 1'b0, 1'b1, 1'b0);
    JMP = 1'b1; JMP_TARGET = 32'h300;
    step("halt_jmp", 32'h300, 1'b0, 1'b1, 1'b0);
    JMP = 1'b0; HALT_REQ = 1'b1; RESUME = 1'b1;
    step("halt_both", 32'h300, 1'b0, 1'b1, 1'b0);
    HALT_REQ = 1'b0;
    step("resume", 32'h300, 1'b1, 1'b0, 1'b0);
    RESUME = 1'b0;
    step("res_seq", 32'h304, 1'b1, 1'b0, 1'b0);

    // Halt with same-cycle handshake
    HALT_REQ = 1'b1;
    step("halt_now", 32'h308, 1'b0, 1'b1, 1'b0);
    HALT_REQ = 1'b0; RESUME = 1'b1;
    step("resume2", 32'h308, 1'b1, 1'b0, 1'b0);
    RESUME = 1'b0;

    // Pending redirect consumed on entry to HALTED
    FETCH_READY = 1'b0; HALT_REQ = 1'b1; BR_TAKEN = 1'b1; BR_TARGET = 32'h900;
    step("drain_pend", 32'h308, 1'b1, 1'b0, 1'b1);
    BR_TAKEN = 1'b0; HALT_REQ = 1'b0; FETCH_READY = 1'b1;
    step("halt_pend", 32'h900, 1'b0, 1'b1, 1'b0);
    RESUME = 1'b1;
    step("resume3", 32'h900, 1'b1, 1'b0, 1'b0);
    RESUME = 1'b0;

    // Wrap-around
    JMP = 1'b1; JMP_TARGET = 32'hFFFF_FFFC;
    step("top", 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    JMP = 1'b0;
    step("wrap0", 32'h0, 1'b1, 1'b0, 1'b0);
    step("wrap4", 32'h4, 1'b1, 1'b0, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
    BR_TAKEN = 1'b1; BR_TARGET = 32'h106;
    step("misal", 32'h104, 1'b1, 1'b0, 1'b0);
    chk("misal.flag", {31'd0, MISALIGN}, 32'd1);
    BR_TAKEN = 1'b0; JMP = 1'b1; JMP_TARGET = 32'h200;
    step("misal_sticky", 32'h200, 1'b1, 1'b0, 1'b0);
    chk("misal_sticky.flag", {31'd0, MISALIGN}, 32'd1);
    JMP = 1'b0;
    step("seq204", 32'h204, 1'b1, 1'b0, 1'b0);
`endif

    // Async reset during DRAIN
    FETCH_READY = 1'b0; HALT_REQ = 1'b1;
    step("pre_rst", PC_OUT, 1'b1, 1'b0, 1'b0);
    HALT_REQ = 1'b0;
    #1;
    RST_N = 1'b0;
    #1;
    push("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
    drain_check();
`ifdef PC_ALIGN_CHECK_EN
    chk("rst_mid.misalign", {31'd0, MISALIGN}, 32'd0);
`endif

    // Redirect during BOOT loads PC directly
    @(posedge CLK); #1;
    RST_N = 1'b1; JMP = 1'b1; JMP_TARGET = 32'h40;
    step("boot_jmp", 32'h40, 1'b1, 1'b0, 1'b0);
    JMP = 1'b0; FETCH_READY = 1'b1;
    step("boot_seq", 32'h44, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
